// File: rtl/sobel_window_gen_pkg.sv
// Shared types for the Sobel window path: pixel width, window structs,
// window-generator states and the position-counter width helper.
package sobel_window_gen_pkg;

   localparam int unsigned PIXEL_WIDTH = 8;

   typedef logic [PIXEL_WIDTH-1:0] pixel_t;

   typedef struct packed {
      pixel_t pix0;
      pixel_t pix1;
      pixel_t pix2;
   } sobel_vector;

   typedef struct packed {
      sobel_vector vector0;
      sobel_vector vector1;
      sobel_vector vector2;
   } sobel_matrix;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRIME,
      ST_STREAM
   } win_state_e;

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of pixel storage: registered write and asynchronous read
// at the same address, so a read-modify-write completes in one accept.
module sobel_line_buffer
   import sobel_window_gen_pkg::*;
#(
   parameter int unsigned DEPTH  = 640,
   parameter int unsigned WIDTH  = PIXEL_WIDTH,
   parameter int unsigned ADDR_W = cnt_width(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [WIDTH-1:0]  wdata_i,
   output logic [WIDTH-1:0]  rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // NOTE: the storage array is deliberately left out of reset so it maps onto plain RAM.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator feeding sobel_core from a raster pixel stream.
// Optional end-of-line/end-of-frame flags are built when SOBEL_WINDOW_EOF_EN is defined.
module sobel_window_gen
   import sobel_window_gen_pkg::*;
#(
   parameter int unsigned IMG_WIDTH  = 640,
   parameter int unsigned IMG_HEIGHT = 480
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [PIXEL_WIDTH-1:0] pixel_i,
   input  logic                   pixel_sof_i,
   input  logic                   pixel_valid_i,
   output logic                   pixel_ready_o,
   output sobel_matrix            matrix_pixels_o,
   output logic                   matrix_valid_o,
   input  logic                   matrix_ready_i
`ifdef SOBEL_WINDOW_EOF_EN
   ,
   output logic                   line_last_o,
   output logic                   frame_last_o
`endif
);

   localparam int unsigned COL_W = cnt_width(IMG_WIDTH);
   localparam int unsigned ROW_W = cnt_width(IMG_HEIGHT);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
   localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

   logic [COL_W-1:0] col_q, col_d, eff_col;
   logic [ROW_W-1:0] row_q, row_d, eff_row;
   win_state_e       state_q, state_d;
   sobel_matrix      win_q, win_d;
   logic             valid_q, valid_d;
   logic             accept, emit, col_last, row_last;
   logic [PIXEL_WIDTH-1:0] lb0_rdata, lb1_rdata;
`ifdef SOBEL_WINDOW_EOF_EN
   logic             line_last_q, line_last_d;
   logic             frame_last_q, frame_last_d;
`endif

   assign pixel_ready_o = !valid_q || matrix_ready_i;
   assign accept        = pixel_valid_i && pixel_ready_o;

   // An SOF pixel is position (0,0) whatever the counters say.
   assign eff_col  = pixel_sof_i ? '0 : col_q;
   assign eff_row  = pixel_sof_i ? '0 : row_q;
   assign col_last = (eff_col == COL_LAST);
   assign row_last = (eff_row == ROW_LAST);

   sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_WIDTH), .ADDR_W(COL_W)) u_lb0 (
      .clk_i   (clk_i),
      .we_i    (accept),
      .addr_i  (eff_col),
      .wdata_i (pixel_i),
      .rdata_o (lb0_rdata)
   );

   sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_WIDTH), .ADDR_W(COL_W)) u_lb1 (
      .clk_i   (clk_i),
      .we_i    (accept),
      .addr_i  (eff_col),
      .wdata_i (lb0_rdata),
      .rdata_o (lb1_rdata)
   );

   // NOTE: every always_comb output gets a default first so no path leaves a latch.
   always_comb begin
      col_d   = col_q;
      row_d   = row_q;
      state_d = state_q;
      win_d   = win_q;
      emit    = 1'b0;
      if (accept) begin
         if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : eff_row + 1'b1;
         end else begin
            col_d = eff_col + 1'b1;
            row_d = eff_row;
         end
         win_d.vector0.pix0 = win_q.vector0.pix1;
         win_d.vector0.pix1 = win_q.vector0.pix2;
         win_d.vector0.pix2 = lb1_rdata;
         win_d.vector1.pix0 = win_q.vector1.pix1;
         win_d.vector1.pix1 = win_q.vector1.pix2;
         win_d.vector1.pix2 = lb0_rdata;
         win_d.vector2.pix0 = win_q.vector2.pix1;
         win_d.vector2.pix1 = win_q.vector2.pix2;
         win_d.vector2.pix2 = pixel_i;
         emit = (state_q == ST_STREAM) && !pixel_sof_i &&
                (eff_row >= ROW_TWO) && (eff_col >= COL_TWO);
         unique case (state_q)
            ST_IDLE:   state_d = ST_PRIME;
            ST_PRIME:  if (row_d == ROW_TWO) state_d = ST_STREAM;
            ST_STREAM: if (pixel_sof_i || (col_last && row_last)) state_d = ST_PRIME;
            default:   state_d = ST_IDLE;
         endcase
      end
      valid_d = emit ? 1'b1 : (matrix_ready_i ? 1'b0 : valid_q);
`ifdef SOBEL_WINDOW_EOF_EN
      line_last_d  = emit ? col_last : (matrix_ready_i ? 1'b0 : line_last_q);
      frame_last_d = emit ? (col_last && row_last) : (matrix_ready_i ? 1'b0 : frame_last_q);
`endif
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         col_q        <= '0;
         row_q        <= '0;
         state_q      <= ST_IDLE;
         win_q        <= '0;
         valid_q      <= 1'b0;
`ifdef SOBEL_WINDOW_EOF_EN
         line_last_q  <= 1'b0;
         frame_last_q <= 1'b0;
`endif
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         state_q      <= state_d;
         win_q        <= win_d;
         valid_q      <= valid_d;
`ifdef SOBEL_WINDOW_EOF_EN
         line_last_q  <= line_last_d;
         frame_last_q <= frame_last_d;
`endif
      end
   end

   assign matrix_pixels_o = win_q;
   assign matrix_valid_o  = valid_q;
`ifdef SOBEL_WINDOW_EOF_EN
   assign line_last_o     = line_last_q;
   assign frame_last_o    = frame_last_q;
`endif

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 4x4 image; pixel value = offset + row*16 + col.
module tb_sobel_window_gen;
   import sobel_window_gen_pkg::*;

   localparam int W = 4;
   localparam int H = 4;

   logic        clk_i;
   logic        rst_i;
   logic [7:0]  pixel_i;
   logic        pixel_sof_i;
   logic        pixel_valid_i;
   logic        pixel_ready_o;
   sobel_matrix matrix_pixels_o;
   logic        matrix_valid_o;
   logic        matrix_ready_i;
`ifdef SOBEL_WINDOW_EOF_EN
   logic        line_last_o;
   logic        frame_last_o;
   logic [1:0]  q_flags [$];
`endif

   int          tests_run;
   int          tests_failed;
   sobel_matrix q_win [$];

   sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .pixel_i         (pixel_i),
      .pixel_sof_i     (pixel_sof_i),
      .pixel_valid_i   (pixel_valid_i),
      .pixel_ready_o   (pixel_ready_o),
      .matrix_pixels_o (matrix_pixels_o),
      .matrix_valid_o  (matrix_valid_o),
      .matrix_ready_i  (matrix_ready_i)
`ifdef SOBEL_WINDOW_EOF_EN
      ,
      .line_last_o     (line_last_o),
      .frame_last_o    (frame_last_o)
`endif
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // Record every window handed over downstream (valid && ready at the coming edge).
   always @(negedge clk_i) begin
      if (!rst_i && matrix_valid_o && matrix_ready_i) begin
         q_win.push_back(matrix_pixels_o);
`ifdef SOBEL_WINDOW_EOF_EN
         q_flags.push_back({frame_last_o, line_last_o});
`endif
      end
   end

   function automatic logic [7:0] pv(input logic [7:0] off, input int r, input int c);
      return off + 8'(r * 16 + c);
   endfunction

   // Window produced by accepting pixel (r,c): rows r-2..r, columns c-2..c.
   function automatic sobel_matrix exp_win(input logic [7:0] off, input int r, input int c);
      sobel_matrix m;
      m.vector0.pix0 = pv(off, r-2, c-2);
      m.vector0.pix1 = pv(off, r-2, c-1);
      m.vector0.pix2 = pv(off, r-2, c);
      m.vector1.pix0 = pv(off, r-1, c-2);
      m.vector1.pix1 = pv(off, r-1, c-1);
      m.vector1.pix2 = pv(off, r-1, c);
      m.vector2.pix0 = pv(off, r,   c-2);
      m.vector2.pix1 = pv(off, r,   c-1);
      m.vector2.pix2 = pv(off, r,   c);
      return m;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   // Offer one pixel and return #1 after the edge that accepted it.
   task automatic send_pixel(input logic [7:0] val, input logic sof);
      logic rdy;
      rdy           = 1'b0;
      pixel_i       = val;
      pixel_sof_i   = sof;
      pixel_valid_i = 1'b1;
      for (int t = 0; t < 16 && !rdy; t++) begin
         @(negedge clk_i);
         rdy = pixel_ready_o;
         @(posedge clk_i);
         #1;
      end
      pixel_valid_i = 1'b0;
      pixel_sof_i   = 1'b0;
      if (!rdy) begin
         tests_run++;
         tests_failed++;
         $display("FAIL accept_timeout: pixel %h not accepted within 16 cycles", val);
      end
   endtask

   task automatic drive_range(input logic [7:0] off, input int first, input int last, input int sof_idx);
      for (int i = first; i <= last; i++) begin
         send_pixel(pv(off, i / W, i % W), i == sof_idx);
      end
   endtask

   task automatic test_reset;
      rst_i          = 1'b1;
      pixel_valid_i  = 1'b0;
      pixel_sof_i    = 1'b0;
      pixel_i        = '0;
      matrix_ready_i = 1'b1;
      idle(3);
      rst_i = 1'b0;
      tests_run++;
      if (matrix_valid_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_valid: got %b want 0", matrix_valid_o);
      end
      tests_run++;
      if (pixel_ready_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_ready: got %b want 1", pixel_ready_o);
      end
      tests_run++;
      if (matrix_pixels_o !== '0) begin
         tests_failed++;
         $display("FAIL reset_pixels: got %h want 0", matrix_pixels_o);
      end
   endtask

   task automatic test_stream;
      logic exp_v;
      q_win.delete();
`ifdef SOBEL_WINDOW_EOF_EN
      q_flags.delete();
`endif
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            send_pixel(pv(8'h00, r, c), r == 0 && c == 0);
            exp_v = (r >= 2) && (c >= 2);
            tests_run++;
            if (matrix_valid_o !== exp_v) begin
               tests_failed++;
               $display("FAIL stream_valid r%0d c%0d: got %b want %b", r, c, matrix_valid_o, exp_v);
            end
            if (exp_v) begin
               tests_run++;
               if (matrix_pixels_o !== exp_win(8'h00, r, c)) begin
                  tests_failed++;
                  $display("FAIL stream_win r%0d c%0d: got %h want %h", r, c, matrix_pixels_o, exp_win(8'h00, r, c));
               end
            end
         end
      end
      idle(3);
      tests_run++;
      if (q_win.size() !== 4) begin
         tests_failed++;
         $display("FAIL stream_count: got %0d want 4", q_win.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (q_win[i] !== exp_win(8'h00, 2 + i / 2, 2 + i % 2)) begin
               tests_failed++;
               $display("FAIL stream_q%0d: got %h want %h", i, q_win[i], exp_win(8'h00, 2 + i / 2, 2 + i % 2));
            end
`ifdef SOBEL_WINDOW_EOF_EN
            tests_run++;
            if (q_flags[i] !== {i == 3, i % 2 == 1}) begin
               tests_failed++;
               $display("FAIL eof_flags%0d: got %b want %b", i, q_flags[i], {i == 3, i % 2 == 1});
            end
`endif
         end
      end
   endtask

   task automatic test_backpressure;
      q_win.delete();
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            send_pixel(pv(8'h10, r, c), r == 0 && c == 0);
            if (r == 2 && c == 2) begin
               matrix_ready_i = 1'b0;
               for (int s = 0; s < 3; s++) begin
                  idle(1);
                  tests_run++;
                  if (matrix_valid_o !== 1'b1 || pixel_ready_o !== 1'b0) begin
                     tests_failed++;
                     $display("FAIL bp_hold%0d: valid %b ready %b want 1 0", s, matrix_valid_o, pixel_ready_o);
                  end
                  tests_run++;
                  if (matrix_pixels_o !== exp_win(8'h10, 2, 2)) begin
                     tests_failed++;
                     $display("FAIL bp_stable%0d: got %h want %h", s, matrix_pixels_o, exp_win(8'h10, 2, 2));
                  end
               end
               matrix_ready_i = 1'b1;
            end
         end
      end
      idle(3);
      tests_run++;
      if (q_win.size() !== 4) begin
         tests_failed++;
         $display("FAIL bp_count: got %0d want 4", q_win.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (q_win[i] !== exp_win(8'h10, 2 + i / 2, 2 + i % 2)) begin
               tests_failed++;
               $display("FAIL bp_q%0d: got %h want %h", i, q_win[i], exp_win(8'h10, 2 + i / 2, 2 + i % 2));
            end
         end
      end
   endtask

   // Second frame relies on the counter wrap alone (no SOF).
   task automatic test_back_to_back;
      logic exp_v;
      q_win.delete();
      drive_range(8'h00, 0, W * H - 1, 0);
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            send_pixel(pv(8'h80, r, c), 1'b0);
            exp_v = (r >= 2) && (c >= 2);
            tests_run++;
            if (matrix_valid_o !== exp_v) begin
               tests_failed++;
               $display("FAIL b2b_valid r%0d c%0d: got %b want %b", r, c, matrix_valid_o, exp_v);
            end
         end
      end
      idle(3);
      tests_run++;
      if (q_win.size() !== 8) begin
         tests_failed++;
         $display("FAIL b2b_count: got %0d want 8", q_win.size());
      end else begin
         tests_run++;
         if (q_win[4] !== exp_win(8'h80, 2, 2)) begin
            tests_failed++;
            $display("FAIL b2b_first: got %h want %h", q_win[4], exp_win(8'h80, 2, 2));
         end
         tests_run++;
         if (q_win[7] !== exp_win(8'h80, 3, 3)) begin
            tests_failed++;
            $display("FAIL b2b_last: got %h want %h", q_win[7], exp_win(8'h80, 3, 3));
         end
      end
   endtask

   // Old frame stops at (1,2); SOF arrives where (1,3) would have been.
   task automatic test_sof_resync;
      logic exp_v;
      q_win.delete();
      drive_range(8'h00, 0, 6, 0);
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            send_pixel(pv(8'h40, r, c), r == 0 && c == 0);
            exp_v = (r >= 2) && (c >= 2);
            tests_run++;
            if (matrix_valid_o !== exp_v) begin
               tests_failed++;
               $display("FAIL sof_valid r%0d c%0d: got %b want %b", r, c, matrix_valid_o, exp_v);
            end
         end
      end
      idle(3);
      tests_run++;
      if (q_win.size() !== 4) begin
         tests_failed++;
         $display("FAIL sof_count: got %0d want 4", q_win.size());
      end else begin
         tests_run++;
         if (q_win[0] !== exp_win(8'h40, 2, 2)) begin
            tests_failed++;
            $display("FAIL sof_first: got %h want %h", q_win[0], exp_win(8'h40, 2, 2));
         end
         tests_run++;
         if (q_win[3] !== exp_win(8'h40, 3, 3)) begin
            tests_failed++;
            $display("FAIL sof_last: got %h want %h", q_win[3], exp_win(8'h40, 3, 3));
         end
      end
   endtask

   task automatic test_reset_mid;
      q_win.delete();
      drive_range(8'h20, 0, 10, 0);
      matrix_ready_i = 1'b0;
      idle(1);
      tests_run++;
      if (matrix_valid_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL rst_pending: got %b want 1", matrix_valid_o);
      end
      rst_i = 1'b1;
      idle(1);
      rst_i = 1'b0;
      tests_run++;
      if (matrix_valid_o !== 1'b0 || matrix_pixels_o !== '0) begin
         tests_failed++;
         $display("FAIL rst_drop: valid %b pixels %h want 0 0", matrix_valid_o, matrix_pixels_o);
      end
      matrix_ready_i = 1'b1;
      q_win.delete();
      drive_range(8'h30, 0, W * H - 1, 0);
      idle(3);
      tests_run++;
      if (q_win.size() !== 4) begin
         tests_failed++;
         $display("FAIL rst_count: got %0d want 4", q_win.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (q_win[i] !== exp_win(8'h30, 2 + i / 2, 2 + i % 2)) begin
               tests_failed++;
               $display("FAIL rst_q%0d: got %h want %h", i, q_win[i], exp_win(8'h30, 2 + i / 2, 2 + i % 2));
            end
         end
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_stream();
      test_backpressure();
      test_back_to_back();
      test_sof_resync();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Streaming 3x3 window generator for the Sobel path: it accepts a raster pixel stream and emits `sobel_matrix` windows that `sobel_core` consumes directly. Two internal line buffers hold the previous image rows, and a 3x3 register array forms each window. Windows are produced only where a full 3x3 neighbourhood exists, so a W x H frame yields (W-2) x (H-2) windows. Valid/ready handshakes on both sides let the block sit between the pixel source and the core/output stage.

## Interface
- `IMG_WIDTH`, default 640: pixels per line, must be ≥ 3.
- `IMG_HEIGHT`, default 480: lines per frame, must be ≥ 3.
- `clk_i` input, 1 bit: clock.
- `rst_i` input, 1 bit: reset, synchronous, active-high.
- `pixel_i` input, `PIXEL_WIDTH` bits: input pixel, raster order.
- `pixel_sof_i` input, 1 bit: marks the first pixel of a frame; sampled with `pixel_i`.
- `pixel_valid_i` input, 1 bit: input pixel valid.
- `pixel_ready_o` output, 1 bit: input can be accepted.
- `matrix_pixels_o` output, `sobel_matrix`: window. `vector0` is the top row (r-2), `vector2` is the current row. `pix0` is the left column (c-2), `pix2` is the current column.
- `matrix_valid_o` output, 1 bit: window valid.
- `matrix_ready_i` input, 1 bit: downstream accepts the window.

## Operation
- Accept = `pixel_valid_i && pixel_ready_o`. `pixel_ready_o = !matrix_valid_o || matrix_ready_i` (single output register with skid-free backpressure).
- Counters `col` (0..IMG_WIDTH-1) and `row` (0..IMG_HEIGHT-1) give the position of the accepted pixel.
  - `col` wraps to 0 and increments `row`.
  - At (W-1, H-1), both wrap to 0.
- An accepted pixel with `pixel_sof_i=1` is treated as position (0,0) regardless of the counters; the counters continue from (1,0). The line buffer contents are not cleared, but no window is emitted until row ≥ 2 again.
- On accept:
  - read `lb1[col]` (row r-2) and `lb0[col]` (row r-1);
  - write `lb1[col] <= lb0[col]` and `lb0[col] <= pixel_i`;
  - shift the window left (pix0 <= pix1, pix1 <= pix2);
  - load the new column: vector0.pix2 = old `lb1[col]`, vector1.pix2 = old `lb0[col]`, vector2.pix2 = `pixel_i`.
- Window emit: an accepted pixel with row ≥ 2 and col ≥ 2 sets `matrix_valid_o` on the next edge.
- `matrix_valid_o` clears when `matrix_ready_i=1` and no new emit occurs. The window register updates only on accept.
- FSM:
  - IDLE (after reset, before any accepted pixel) → PRIME on the first accept.
  - PRIME (row < 2) → STREAM when row becomes 2.
  - STREAM → PRIME on a frame wrap or an accepted SOF.
  - Windows are emitted only in STREAM.
- Pixel data is unsigned, with no arithmetic. Widths are passed through unchanged.

## Timing
- Latency: 1 cycle from accepting pixel (r, c) to `matrix_valid_o` with the window centred at (r-1, c-1).
- Throughput: 1 window per cycle when `matrix_ready_i` is held high.
- Reset values: `pixel_ready_o`=1 (derived), `matrix_valid_o`=0, `matrix_pixels_o`=0, counters 0, state IDLE. Line buffer contents are undefined and not reset.
- Reset mid-frame drops any pending window. The next frame must start with SOF or at (0,0).
- Simultaneous drain and accept-with-emit keeps `matrix_valid_o`=1 and presents the new window.
- Backpressure: while `matrix_valid_o && !matrix_ready_i`, `pixel_ready_o`=0 and the window stays stable.

## Configuration
- `SOBEL_WINDOW_EOF_EN` defined:
  - adds output `frame_last_o` (1 bit), asserted with the window centred at (W-2, H-2), i.e. the last window of the frame;
  - adds output `line_last_o` (1 bit), asserted with each window whose col = W-1 at emit;
  - both are registered alongside `matrix_valid_o` and reset to 0.
- Not defined: these ports and their logic are absent.

## Structure
- `sobel_matrix`, `PIXEL_WIDTH` and any position-counter widths (`$clog2(IMG_WIDTH)`, `$clog2(IMG_HEIGHT)` helpers) belong in the shared sobel control package/header.
- Sub-module `sobel_line_buffer`:
  - depth `IMG_WIDTH`, width `PIXEL_WIDTH`;
  - one write port with registered write and asynchronous read at the same address;
  - instantiated twice.

## Test plan
- 4x4 frame, pixel = row*16+col, SOF on the first pixel, ready held high:
  - exactly 4 windows;
  - the first window arrives 1 cycle after accepting (2,2), with vector0={00,01,02}, vector1={10,11,12}, vector2={20,21,22}.
- Same frame with `matrix_ready_i` low for 3 cycles after the first window:
  - window held stable;
  - `pixel_ready_o`=0 for those cycles;
  - no window lost or duplicated.
- Two back-to-back 4x4 frames: the second frame emits no window before its pixel (2,2), and its first window equals {00..22} of the new data.
- SOF asserted at pixel (1,3) mid-frame: the counters resync, and no window is emitted until row 2 of the new frame.
- `rst_i` pulsed with a window pending: `matrix_valid_o`=0 on the next cycle, and a fresh frame produces correct windows.
- With `SOBEL_WINDOW_EOF_EN` on a 4x4 frame: `line_last_o` is high on windows 2 and 4, and `frame_last_o` is high only on window 4.
